fb_scanout_reader: RTL and testbench
====================================

Name: fb_scanout_reader

Overview:
- Downstream consumer of the SRAM frame buffer that the draw engine fills.
- On each active video line, reads 640 16-bit pixel words for the selected frame from SRAM and queues them in a small prefetch FIFO.
- Hands pixels to the VGA colour mapper one word per pop, owning the SRAM bus only while the shared-bus arbiter grants it.
- Read-only: drives OE low and WE high and never writes. The external tristate stays under the draw engine's control.

Parameters:
- H_PIXELS, 640, pixel words fetched per line.
- V_LINES, 480, highest valid line index is V_LINES-1.
- FIFO_DEPTH, 16, prefetch FIFO entries (power of two).
- ADDR_W, 20, SRAM word address width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- frame_sel  in  1  frame to scan out; becomes ADDR[19]; sampled at line_start.
- line_start  in  1  one-cycle pulse before each active line.
- line_y  in  9  line index; valid with line_start.
- pix_pop  in  1  consumer takes the head pixel this cycle.
- pix_data  out  16  head-of-FIFO pixel (first-word-fall-through).
- pix_valid  out  1  FIFO non-empty.
- underrun  out  1  sticky: a pop happened while empty.
- sram_req  out  1  requesting the SRAM bus.
- sram_gnt  in  1  bus granted this cycle.
- SRAM_DQ_in  in  16  read data from the tristate buffer.
- CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes.
- ADDR  out  ADDR_W  SRAM word address.

Behaviour:
- Reset values:
  - State IDLE; FIFO empty.
  - pix_data=0, pix_valid=0, underrun=0, sram_req=0.
  - CE=UB=LB=OE=WE=1; ADDR=0.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - On line_start with line_y<V_LINES: latch base = {frame_sel, line_y*640}, computed as (y<<9)+(y<<7), zero-extended to 19 bits.
  - Clear the issue counter and go to FETCH.
  - line_y>=V_LINES: ignore the pulse and stay in IDLE.
- FETCH:
  - sram_req=1.
  - Issue a read when sram_gnt=1 and (fifo_count + inflight) < FIFO_DEPTH.
  - A read drives CE=UB=LB=OE=0 and ADDR=base+issued for that cycle. The FIFO captures SRAM_DQ_in on the next clock edge (fixed 1-cycle read latency).
  - When issued reaches H_PIXELS-1 and that read issues, go to DRAIN.
- DRAIN:
  - sram_req=0 and strobes deasserted.
  - Wait one cycle for the last in-flight word, then go to IDLE.
- Strobes idle (CE=OE=UB=LB=1) on every cycle without an issued read. WE is held at 1 always.
- Grant dropped mid-line: stop issuing, keep sram_req=1, capture any in-flight word normally, resume at the same address on the next grant.
- line_start in FETCH or DRAIN: abort the current line and flush the FIFO. The in-flight word of that cycle is discarded. Restart FETCH with the new base on the next cycle.
- Pop and push in the same cycle: both happen and the count is unchanged. Pop when full with push pending cannot happen (credit rule).
- pix_pop while empty:
  - pix_data stays 0 and the FIFO is unchanged.
  - underrun is set and stays set until Reset (line_start does not clear it).
- Width rules:
  - ADDR = {frame_sel, 19-bit offset}.
  - Offset max = 479*640+639 = 307199; no wrap.
  - The issued counter is 10 bits.
- frame_sel changes mid-line take effect only at the next line_start.

Decomposition:
- Package fb_pkg holds:
  - constants H_PIXELS, V_LINES, FRAME_WORDS (307200);
  - typedef enum logic [1:0] scan_state_t {IDLE, FETCH, DRAIN};
  - typedef logic [15:0] pixel_t.
- One sub-module: fb_line_fifo.
  - Synchronous first-word-fall-through FIFO, parameter FIFO_DEPTH.
  - Ports: push, push_data, pop, head, count, empty, full; synchronous reset and flush.

Test Plan:
- Reset, then frame_sel=0, line_start with line_y=0, gnt held 1, pix_pop held 0:
  - exactly 16 reads at ADDR 0x00000..0x0000F, then sram_req stays 1 with no strobes;
  - pix_valid=1 and pix_data = word at address 0.
- frame_sel=1, line_y=479, gnt=1, pix_pop=1 continuously after the first pix_valid:
  - ADDR sequence runs 0x80000+306560 through 0x80000+307199;
  - 640 pixels delivered in order; underrun=0; FSM back in IDLE two cycles after the last issue.
- gnt dropped for 5 cycles after the 100th read:
  - no strobes during the gap;
  - next read at base+100;
  - no duplicated or missing pixels.
- line_start with line_y=3 while FETCH of line 2 is at issued=50:
  - FIFO flushed (pix_valid=0 next cycle);
  - next ADDR = 1920; no line-2 data ever appears at pix_data.
- pix_pop asserted for 1 cycle while empty → underrun=1, pix_data=0. A later line_start still reads underrun=1; Reset clears it.
- line_start with line_y=480 → no sram_req, FSM stays IDLE.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scan-out path.
// Holds the video geometry constants, the scan FSM state type, the pixel
// word type and the line base-address helper.
package fb_pkg;

  localparam int H_PIXELS    = 640;
  localparam int V_LINES     = 480;
  localparam int FRAME_WORDS = 307200;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_t;

  typedef logic [15:0] pixel_t;

  // Word offset of the first pixel of line y: y*640 as (y<<9)+(y<<7).
  // The largest value (479*640) fits comfortably in 19 bits.
  function automatic logic [18:0] line_base(input logic [8:0] y);
    logic [18:0] y_w;
    y_w = {10'd0, y};
    return (y_w << 9) + (y_w << 7);
  endfunction

endpackage

// File: rtl/fb_line_fifo.sv
// Synchronous first-word-fall-through prefetch FIFO for scan-out pixels.
// Ports:
//   Clk, Reset    clock and synchronous active-high reset
//   flush         empties the FIFO this cycle (push/pop ignored)
//   push/push_data  write one word (dropped if full and no pop)
//   pop           remove head word (ignored when empty)
//   head          current head word (valid while !empty)
//   count/empty/full  occupancy status
module fb_line_fifo
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           flush,
  input  logic                           push,
  input  pixel_t                         push_data,
  input  logic                           pop,
  output pixel_t                         head,
  output logic [$clog2(FIFO_DEPTH):0]    count,
  output logic                           empty,
  output logic                           full
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  pixel_t             mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_pop_s;
  logic               do_push_s;

  assign empty     = (count_r == CNT_W'(0));
  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy bookkeeping; flush behaves like a reset.
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scan-out reader: fetches one video line of pixel words from
// the shared SRAM while the bus arbiter grants it and hands them to the
// colour mapper through a small FWFT prefetch FIFO. Read-only on the bus.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_sel, line_start, line_y   line request (sampled on line_start)
//   pix_pop / pix_data / pix_valid  consumer side of the prefetch FIFO
//   underrun              sticky flag: pop seen while FIFO empty
//   sram_req / sram_gnt   shared-bus request and grant
//   SRAM_DQ_in            read data, one cycle after the address
//   CE, UB, LB, OE, WE    active-low SRAM strobes
//   ADDR                  SRAM word address {frame, offset}
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_sel,
  input  logic              line_start,
  input  logic [8:0]        line_y,
  input  logic              pix_pop,
  output pixel_t            pix_data,
  output logic              pix_valid,
  output logic              underrun,
  output logic              sram_req,
  input  logic              sram_gnt,
  input  logic [15:0]       SRAM_DQ_in,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int OFF_W = ADDR_W - 1;

  scan_state_t       state_r;
  scan_state_t       state_s;
  logic              frame_r;
  logic [OFF_W-1:0]  base_r;
  logic [9:0]        issued_r;
  logic              inflight_r;
  logic              underrun_r;

  logic [CNT_W-1:0]  count_s;
  logic              empty_s;
  logic              full_s;
  pixel_t            head_s;
  logic              accept_s;
  logic              flush_s;
  logic              push_s;
  logic              rd_s;
  logic [CRD_W-1:0]  credit_s;

  assign accept_s = line_start && (line_y < 9'(V_LINES));
  // A line_start while busy aborts the line, valid line index or not.
  assign flush_s  = line_start && (state_r != IDLE);
  // Credit counts the word still on the bus so the FIFO can never overflow.
  assign credit_s = CRD_W'(count_s) + CRD_W'(inflight_r);
  // No read in a line_start cycle: the old line is being abandoned.
  assign rd_s     = (state_r == FETCH) && sram_gnt && !line_start && !full_s &&
                    (credit_s < CRD_W'(FIFO_DEPTH));
  // The word arriving during an abort cycle belongs to the old line.
  assign push_s   = inflight_r && !flush_s;

  fb_line_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (SRAM_DQ_in),
    .pop       (pix_pop),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // Next-state logic for the line fetch sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = FETCH;
        else          state_s = IDLE;
      end
      FETCH: begin
        if (line_start)                                      state_s = accept_s ? FETCH : IDLE;
        else if (rd_s && (issued_r == 10'(H_PIXELS - 1)))    state_s = DRAIN;
        else                                                 state_s = FETCH;
      end
      DRAIN: begin
        if (line_start) state_s = accept_s ? FETCH : IDLE;
        else            state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, line context, in-flight tracking and sticky underrun.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= IDLE;
      frame_r    <= 1'b0;
      base_r     <= OFF_W'(0);
      issued_r   <= 10'd0;
      inflight_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_s;
      underrun_r <= underrun_r | (pix_pop & empty_s);
      if (accept_s) begin
        frame_r  <= frame_sel;
        base_r   <= OFF_W'(line_base(line_y));
        issued_r <= 10'd0;
      end else if (rd_s) begin
        issued_r <= issued_r + 10'd1;
      end
    end
  end

  assign sram_req  = (state_r == FETCH);
  assign pix_valid = !empty_s;
  assign pix_data  = empty_s ? 16'h0000 : head_s;
  assign underrun  = underrun_r;
  assign CE        = !rd_s;
  assign UB        = !rd_s;
  assign LB        = !rd_s;
  assign OE        = !rd_s;
  assign WE        = 1'b1;
  assign ADDR      = rd_s ? {frame_r, base_r + OFF_W'(issued_r)} : ADDR_W'(0);

endmodule

// File: tb/tb_fb_scanout_reader.sv
module tb_fb_scanout_reader;
  import fb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_sel;
  logic        line_start;
  logic [8:0]  line_y;
  logic        pix_pop;
  pixel_t      pix_data;
  logic        pix_valid;
  logic        underrun;
  logic        sram_req;
  logic        sram_gnt;
  logic [15:0] SRAM_DQ_in;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;

  fb_scanout_reader #(.FIFO_DEPTH(16), .ADDR_W(20)) dut (
    .Clk(Clk), .Reset(Reset), .frame_sel(frame_sel), .line_start(line_start),
    .line_y(line_y), .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .sram_req(sram_req), .sram_gnt(sram_gnt),
    .SRAM_DQ_in(SRAM_DQ_in), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_pct, pop_pct;
  int gap_at, gap_left, abort_at, abort_state;
  logic chk_drain;
  logic [19:0] issue_q[$];
  logic [15:0] pop_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Contents of the simulated frame buffer at word address a.
  function automatic logic [15:0] memf(input logic [19:0] a);
    return a[15:0] + {a[19:16], 12'h9C5};
  endfunction

  // One clock: sample at negedge, then drive the next cycle's inputs.
  task automatic cyc();
    logic rd;
    logic [19:0] ra;
    @(negedge Clk);
    if (abort_state == 2) begin
      check_eq("flush_valid", pix_valid, 0);
      abort_state = 0;
    end
    if (abort_state == 1) begin
      issue_q.delete();
      pop_q.delete();
      abort_state = 2;
    end
    if (chk_drain) begin
      check_eq("drain_req", sram_req, 0);
      chk_drain = 1'b0;
    end
    rd = !CE;
    ra = ADDR;
    if (rd) begin
      issue_q.push_back(ADDR);
      check_eq("rd_strobes", {sram_req, sram_gnt, OE, UB, LB, WE}, 6'b110001);
      if (issue_q.size() == H_PIXELS) chk_drain = 1'b1;
    end
    if (pix_pop && pix_valid) pop_q.push_back(pix_data);
    @(posedge Clk);
    #1;
    SRAM_DQ_in = rd ? memf(ra) : 16'($urandom);
    line_start = 1'b0;
    if (gap_at >= 0 && issue_q.size() == gap_at) begin
      gap_left = 5;
      gap_at = -1;
    end
    if (gap_left > 0) begin
      sram_gnt = 1'b0;
      gap_left--;
    end else begin
      sram_gnt = ($urandom_range(0, 99) < gnt_pct);
    end
    pix_pop = pix_valid && ($urandom_range(0, 99) < pop_pct);
    if (abort_at >= 0 && issue_q.size() == abort_at) begin
      line_start = 1'b1;
      line_y = 9'd3;
      frame_sel = 1'b0;
      pix_pop = 1'b0;
      abort_at = -1;
      abort_state = 1;
    end
  endtask

  task automatic start_line(input logic fs, input int y);
    frame_sel  = fs;
    line_y     = 9'(y);
    line_start = 1'b1;
    cyc();
  endtask

  // Run until the whole line is fetched and drained, then compare against model.
  task automatic finish_line(input logic [19:0] base);
    int t;
    int ok;
    t = 0;
    while (!(issue_q.size() >= H_PIXELS && !sram_req) && t < 30000) begin
      cyc();
      t++;
    end
    check_eq("reads_done", issue_q.size(), H_PIXELS);
    pop_pct = 100;
    t = 0;
    while ((pix_valid || t < 4) && t < 300) begin
      cyc();
      t++;
    end
    check_eq("fifo_drained", pix_valid, 0);
    ok = 0;
    while (ok < issue_q.size() && issue_q[ok] === base + 20'(ok)) ok++;
    check_eq("addr_seq_ok", ok, H_PIXELS);
    check_eq("pix_count", pop_q.size(), H_PIXELS);
    ok = 0;
    while (ok < pop_q.size() && pop_q[ok] === memf(base + 20'(ok))) ok++;
    check_eq("pix_seq_ok", ok, H_PIXELS);
    check_eq("no_underrun", underrun, 0);
    issue_q.delete();
    pop_q.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    line_start = 1'b0;
    pix_pop = 1'b0;
    sram_gnt = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_eq("rst_outs", {pix_data, pix_valid, underrun, sram_req, CE, UB, LB, OE, WE},
             {16'h0000, 3'b000, 5'b11111});
    check_eq("rst_addr", ADDR, 0);
    issue_q.delete();
    pop_q.delete();
    gap_at = -1; gap_left = 0; abort_at = -1; abort_state = 0; chk_drain = 1'b0;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic fs;
    int y;
    logic req_seen;
    frame_sel = 1'b0; line_y = 9'd0; SRAM_DQ_in = 16'h0000;
    gnt_pct = 100; pop_pct = 0;
    do_reset();

    // Line 0, frame 0, no pops: exactly one FIFO worth of reads.
    gnt_pct = 100; pop_pct = 0;
    start_line(1'b0, 0);
    repeat (40) cyc();
    check_eq("prefetch_reads", issue_q.size(), 16);
    check_eq("prefetch_req", sram_req, 1);
    check_eq("prefetch_valid", pix_valid, 1);
    check_eq("prefetch_head", pix_data, memf(20'd0));
    gnt_pct = 70; pop_pct = 60;
    finish_line(20'd0);

    // Last line of frame 1 with continuous consumption.
    gnt_pct = 100; pop_pct = 100;
    start_line(1'b1, 479);
    finish_line(20'h80000 + 20'd306560);

    // Grant gap of five cycles after the 100th read.
    y = $urandom_range(0, 479);
    gnt_pct = 100; pop_pct = 50; gap_at = 100;
    start_line(1'b0, y);
    finish_line({1'b0, 19'(y * 640)});

    // Abort line 2 at 50 reads with a line_start for line 3.
    gnt_pct = 100; pop_pct = 30; abort_at = 50;
    start_line(1'b0, 2);
    finish_line(20'd1920);

    // Random lines; frame_sel toggled mid-line must not matter.
    for (int k = 0; k < 3; k++) begin
      fs = 1'($urandom);
      y = $urandom_range(0, 479);
      gnt_pct = $urandom_range(40, 100);
      pop_pct = $urandom_range(40, 100);
      start_line(fs, y);
      frame_sel = ~fs;
      finish_line({fs, 19'(y * 640)});
    end

    // Pop while empty sets sticky underrun.
    pop_pct = 0;
    pix_pop = 1'b1;
    cyc();
    check_eq("underrun_set", underrun, 1);
    check_eq("empty_pop_data", pix_data, 0);
    check_eq("empty_pop_valid", pix_valid, 0);
    gnt_pct = 100; pop_pct = 100;
    start_line(1'b0, 10);
    repeat (20) cyc();
    check_eq("underrun_sticky", underrun, 1);
    do_reset();
    check_eq("underrun_cleared", underrun, 0);

    // Out-of-range line index is ignored.
    gnt_pct = 100; pop_pct = 0;
    start_line(1'b0, 480);
    req_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      req_seen = req_seen | sram_req;
    end
    check_eq("bad_line_req", req_seen, 0);
    check_eq("bad_line_reads", issue_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
